rf_writeback_ctrl: RTL and testbench
====================================

// Module: rf_writeback_ctrl
// PURPOSE
//   Writer side of the 32x32 register file write port (A3/WD/RegWrite). Merges
//   two writeback sources: ALU results (valid/ready) and load results (valid/
//   ready, buffered in a DEPTH-entry FIFO). Issues at most one registered write
//   per cycle, never writes x0, and flags pending load destinations for hazard logic.
// PARAMETERS
//   XLEN        32  data width of WD, alu_wd, ld_wd
//   DEPTH       4   load FIFO entries, power of 2, >=2
//   STARVE_MAX  3   cycles a non-empty FIFO head may wait before the ALU is stalled
// PORTS
//   CLK        in   1           system clock, all state on posedge
//   RST        in   1           reset, synchronous, active-high
//   alu_valid  in   1           ALU result available
//   alu_ready  out  1           ALU result accepted when alu_valid & alu_ready
//   alu_rd     in   5           ALU destination register
//   alu_wd     in   XLEN        ALU result data
//   ld_valid   in   1           load result available
//   ld_ready   out  1           load result accepted when ld_valid & ld_ready
//   ld_rd      in   5           load destination register
//   ld_wd      in   XLEN        load result data
//   q_rs       in   5           hazard query register index
//   q_pend     out  1           q_rs has an uncommitted load or output-stage write
//   ld_count   out  log2(DEPTH)+1  FIFO occupancy
//   A3         out  5           register file write address (registered)
//   WD         out  XLEN        register file write data (registered)
//   RegWrite   out  1           register file write enable (registered)
// BEHAVIOUR
//   Reset: A3=0, WD=0, RegWrite=0, FIFO empty, ld_count=0, starve_cnt=0.
//     While RST=1: alu_ready=0, ld_ready=0, inputs ignored; reset mid-operation
//     flushes FIFO and drops the in-flight write (RegWrite=0 on next cycle).
//   ld_ready = !RST & (ld_count < DEPTH); no pass-through when full, even if popping.
//   force = fifo_nonempty & (starve_cnt == STARVE_MAX); alu_ready = !RST & !force.
//   rd==0 transactions (either source): handshake completes, data discarded,
//     no FIFO entry, no RegWrite.
//   Per-cycle selection (priority):
//     1. ALU fire with alu_rd!=0 -> output write {alu_rd, alu_wd}.
//     2. else FIFO non-empty -> pop head, output write {head.rd, head.wd}.
//     3. else RegWrite<=0; A3/WD hold last values.
//   Load push at same edge as pop allowed when not full; ld_count += push - pop.
//   Latency: selection at edge N -> A3/WD/RegWrite valid in cycle N+1, committed
//     to register file at edge N+1. Load accepted into empty FIFO with no ALU
//     write: output one cycle later (push edge N, pop edge N+1, visible N+2).
//   starve_cnt: 0 when FIFO empty or on pop; else +1 per cycle, saturates at STARVE_MAX.
//   Ordering: loads retire in acceptance order; ALU vs load order to the same
//     rd not enforced here -- upstream stalls on q_pend.
//   q_pend (combinational) = (q_rs!=0) & (any FIFO entry rd==q_rs |
//     (RegWrite & A3==q_rs)).
//   FIFO pointers wrap modulo DEPTH; full/empty from ld_count, not pointer compare.
// TESTING
//   Reset: RST=1 two cycles, alu_valid=ld_valid=1 -> ready outputs 0, RegWrite=0, ld_count=0.
//   ALU write: alu rd=5 wd=0xDEADBEEF at edge 0 -> cycle 1 RegWrite=1 A3=5 WD=0xDEADBEEF; cycle 2 RegWrite=0.
//   Contention: alu rd=1 wd=0x11 and ld rd=2 wd=0x22 same edge -> ALU write cycle 1,
//     load write cycle 2; q_pend(q_rs=2)=1 through cycle 2, 0 in cycle 3.
//   Starvation: one load queued, alu_valid=1 continuously -> 3 ALU writes, alu_ready=0 one cycle, load written, alu_ready back to 1.
//   Full: 4 loads while ALU saturates -> ld_count=4, ld_ready=0; 5th load held, accepted the cycle after first pop, order preserved.
//   x0: alu rd=0 and ld rd=0 accepted -> RegWrite stays 0, ld_count stays 0, q_pend(0)=0.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// Register file write-port arbiter: merges ALU and load writebacks into one
// registered write per cycle, with a load FIFO and a starvation guard for it.
module rf_writeback_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_wd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_wd,
  input  logic [4:0]               q_rs,
  output logic                     q_pend,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic [4:0]               A3,
  output logic [XLEN-1:0]          WD,
  output logic                     RegWrite
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } wb_t;

  wb_t           mem_q [DEPTH];
  wb_t           mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rw_q, rw_d;
  logic [4:0]    a3_q, a3_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic fifo_empty, fifo_full, force_pop;
  logic alu_fire, ld_fire, alu_wr, push, pop;
  wb_t  head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // Once the head has waited long enough, the ALU is held off for a cycle so the load drains.
  assign force_pop  = !fifo_empty && (starve_q == SW'(STARVE_MAX));

  assign alu_ready = !RST && !force_pop;
  assign ld_ready  = !RST && !fifo_full;

  assign alu_fire = alu_valid && alu_ready;
  assign ld_fire  = ld_valid && ld_ready;
  assign alu_wr   = alu_fire && (alu_rd != 5'd0);
  assign push     = ld_fire && (ld_rd != 5'd0);
  assign pop      = !RST && !alu_wr && !fifo_empty;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    rw_d     = 1'b0;
    a3_d     = a3_q;
    wd_d     = wd_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;

    if (alu_wr) begin
      rw_d = 1'b1;
      a3_d = alu_rd;
      wd_d = alu_wd;
    end else if (pop) begin
      rw_d = 1'b1;
      a3_d = head.rd;
      wd_d = head.wd;
    end

    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: ld_rd, wd: ld_wd};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (fifo_empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  // Hazard query: live FIFO entries are the count_q slots starting at rd_ptr_q.
  logic          fifo_hit;
  logic [PW-1:0] off;
  always_comb begin
    fifo_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_q[i].rd == q_rs))
        fifo_hit = 1'b1;
    end
  end

  assign q_pend = (q_rs != 5'd0) && (fifo_hit || (rw_q && (a3_q == q_rs)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rw_q     <= 1'b0;
      a3_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rw_q     <= rw_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign ld_count = count_q;
  assign A3       = a3_q;
  assign WD       = wd_q;
  assign RegWrite = rw_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios plus random traffic against a
// queue-based reference model of the writeback arbitration rules.
module tb_rf_writeback_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic        alu_ready, ld_ready, q_pend, RegWrite;
  logic [4:0]  alu_rd = '0, ld_rd = '0, q_rs = '0, A3;
  logic [31:0] alu_wd = '0, ld_wd = '0, WD;
  logic [2:0]  ld_count;

  always #5 CLK = ~CLK;

  rf_writeback_ctrl #(.XLEN(32), .DEPTH(4), .STARVE_MAX(3)) dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .q_rs(q_rs), .q_pend(q_pend), .ld_count(ld_count),
    .A3(A3), .WD(WD), .RegWrite(RegWrite)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        fq[$];
  int          m_starve = 0;
  bit          m_rw = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  int          checks = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (m_rw && m_a3 == q) return 1'b1;
    foreach (fq[i]) if (fq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] awd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                      input logic [4:0] qrs);
    bit   ar, lr, was_empty, popped;
    ent_t e;
    RST = rst; alu_valid = av; alu_rd = ard; alu_wd = awd;
    ld_valid = lv; ld_rd = lrd; ld_wd = lwd; q_rs = qrs;
    #1;
    ar = !rst && !(fq.size() > 0 && m_starve == 3);
    lr = !rst && (fq.size() < 4);
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, ar});
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, lr});
    chk("q_pend", {31'b0, q_pend}, {31'b0, m_pend(qrs)});
    @(posedge CLK);
    if (rst) begin
      fq.delete();
      m_starve = 0; m_rw = 1'b0; m_a3 = '0; m_wd = '0;
    end else begin
      was_empty = (fq.size() == 0);
      popped = 1'b0;
      if (av && ar && ard != 5'd0) begin
        m_rw = 1'b1; m_a3 = ard; m_wd = awd;
      end else if (!was_empty) begin
        e = fq.pop_front();
        m_rw = 1'b1; m_a3 = e.rd; m_wd = e.wd;
        popped = 1'b1;
      end else begin
        m_rw = 1'b0;
      end
      if (lv && lr && lrd != 5'd0) begin
        e.rd = lrd; e.wd = lwd;
        fq.push_back(e);
      end
      if (was_empty || popped) m_starve = 0;
      else if (m_starve < 3) m_starve++;
    end
    @(negedge CLK);
    chk("RegWrite", {31'b0, RegWrite}, {31'b0, m_rw});
    chk("A3", {27'b0, A3}, {27'b0, m_a3});
    chk("WD", WD, m_wd);
    chk("ld_count", {29'b0, ld_count}, fq.size());
  endtask

  initial begin
    @(negedge CLK);
    // reset with both sources asserting
    step(1, 1, 5'd7, 32'h1, 1, 5'd9, 32'h2, 5'd7);
    step(1, 1, 5'd7, 32'h1, 1, 5'd9, 32'h2, 5'd7);

    // single ALU write
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 5'd5);
    chk("alu_a3", {27'b0, A3}, 32'd5);
    chk("alu_wd", WD, 32'hDEADBEEF);
    chk("alu_rw", {31'b0, RegWrite}, 32'd1);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5);
    chk("alu_rw_off", {31'b0, RegWrite}, 32'd0);

    // contention: ALU first, load next cycle
    step(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 5'd2);
    chk("cont_a3_1", {27'b0, A3}, 32'd1);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd2);
    chk("cont_a3_2", {27'b0, A3}, 32'd2);
    chk("cont_wd_2", WD, 32'h22);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd2);

    // starvation: one load, ALU saturating
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
    step(0, 1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 5'd4);
    for (int i = 0; i < 6; i++)
      step(0, 1, 5'd3, 32'h31 + i, 0, 5'd0, 32'h0, 5'd4);

    // full FIFO while ALU saturates
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'd6, 32'h60 + i, 1, 5'(8 + i), 32'h80 + i, 5'd9);
    chk("full_cnt", {29'b0, ld_count}, 32'd4);
    for (int i = 0; i < 12; i++)
      step(0, 1, 5'd6, 32'h70 + i, 1, 5'd12, 32'hC0 + i, 5'd12);

    // x0 on both sources
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
    step(0, 1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 5'd0);
    chk("x0_rw", {31'b0, RegWrite}, 32'd0);
    chk("x0_cnt", {29'b0, ld_count}, 32'd0);
    step(0, 1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 5'd0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 80) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           $urandom, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
